uart_apb_master: RTL and testbench
==================================

UART_APB_MASTER -- requirements
Module: uart_apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the ACCESS-phase cycles without PREADY before abort (used only with APB_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port rx_data_in, input, 8, the command-stream byte from the UART RX FIFO.
REQ-005 SHALL have port rx_valid_in, input, 1, meaning rx_data_in is valid.
REQ-006 SHALL have port rx_ready_out, output, 1, meaning the block accepts the RX byte this cycle.
REQ-007 SHALL have port tx_data_out, output, 8, the response byte to the UART TX FIFO.
REQ-008 SHALL have port tx_valid_out, output, 1, meaning tx_data_out is valid.
REQ-009 SHALL have port tx_ready_in, input, 1, meaning the TX FIFO accepts the byte.
REQ-010 SHALL have APB requester outputs PSEL (1), PENABLE (1), PWRITE (1), PADDR (32) and PWDATA (32).
REQ-011 SHALL have APB requester inputs PRDATA (32), PREADY (1) and PSLVERR (1).
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL define a frame as: command byte, 4 address bytes MSB-first, then 4 data bytes MSB-first for writes only.
REQ-014 SHALL treat command 0x57 ('W') as an APB write, 0x52 ('R') as an APB read, and any other byte as consumed, discarded, and leaving the FSM in IDLE.
REQ-015 SHALL use FSM states IDLE, ADDR, WDATA, SETUP, ACCESS, RESP with a 2-bit byte counter.
REQ-016 SHALL transition IDLE->ADDR on a valid command, ADDR->WDATA (write) or ADDR->SETUP (read) after byte 4, WDATA->SETUP after byte 4, SETUP->ACCESS unconditionally, ACCESS->RESP on PREADY=1, and RESP->IDLE after the last response byte.
REQ-017 SHALL drive rx_ready_out high exactly in IDLE, ADDR and WDATA, and accept a byte only on an edge where rx_valid_in && rx_ready_out.
REQ-018 SHALL ignore rx_valid_in in SETUP, ACCESS and RESP, leaving those bytes in the RX FIFO.
REQ-019 SHALL drive PSEL=1, PENABLE=0 in SETUP and PSEL=1, PENABLE=1 in ACCESS, with both 0 in every other state.
REQ-020 SHALL hold PADDR, PWRITE and PWDATA stable from SETUP through the completing ACCESS cycle, and have them retain their last values afterwards.
REQ-021 SHALL complete the transfer on the edge where PENABLE=1 and PREADY=1, capturing PRDATA and PSLVERR on that edge.
REQ-022 SHALL, in RESP, send 0x4B ('K') for a successful write, 0x45 ('E') for any PSLVERR=1, and PRDATA as 4 bytes MSB-first for a successful read.
REQ-023 SHALL hold tx_valid_out=1 in RESP, advance one byte per edge with tx_ready_in=1, and keep tx_data_out stable while tx_ready_in=0.
REQ-024 SHALL keep tx_valid_out=0 outside RESP.
REQ-025 SHALL meet this latency: last frame byte accepted at edge N -> SETUP in cycle N+1 -> ACCESS in cycle N+2 -> first tx_valid_out in cycle N+3 when PREADY=1 in N+2.
REQ-026 SHALL extend ACCESS by exactly one cycle for each wait cycle (PREADY=0).
REQ-027 SHALL register all outputs, with rx_ready_out, busy, PSEL and PENABLE permitted to be decoded directly from state flops.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, enter IDLE and clear the counters, PSEL, PENABLE, PWRITE, tx_valid_out and busy, and set PADDR, PWDATA and tx_data_out to 0.
REQ-029 SHALL, on reset mid-frame or mid-transfer, discard the partial frame and capture no response, with PSEL=0 in the first cycle after the reset edge.
REQ-030 SHALL drive rx_ready_out=0 while rst=1.

Configuration
REQ-031 SHALL, with macro UART_APB_MASTER_TIMEOUT_EN defined, count ACCESS cycles with PREADY=0 in a counter wide enough for TIMEOUT_CYCLES.
REQ-032 SHALL, with UART_APB_MASTER_TIMEOUT_EN defined and the count reaching TIMEOUT_CYCLES, abort: drop PSEL/PENABLE on the next edge and respond 0x45.
REQ-033 SHALL, without the macro, have no timeout counter and wait in ACCESS indefinitely for PREADY.

Verification
REQ-034 SHALL cover: RX 57 00 00 00 04 00 00 00 41, PREADY=1 -> one write to PADDR=0x4 with PWDATA=0x41, PSEL high 2 cycles, then TX 4B.
REQ-035 SHALL cover: RX 52 00 00 00 04, PRDATA=0x00000003, PREADY=1 -> one read, then TX 00 00 00 03 in order.
REQ-036 SHALL cover: a write with PREADY low for 3 cycles -> ACCESS lasts 4 cycles, PADDR/PWDATA stable throughout, then TX 4B.
REQ-037 SHALL cover: a read with PSLVERR=1 on completion -> TX exactly one byte, 45.
REQ-038 SHALL cover: RX 33 then 52 00 00 00 00 -> 33 discarded with no APB activity, then a normal read of address 0.
REQ-039 SHALL cover: timeout build with TIMEOUT_CYCLES=8 and PREADY held 0 -> abort after 8 ACCESS cycles, TX 45; plus rst asserted during ACCESS -> PSEL=0 next cycle, no TX.

Source files
------------

// File: rtl/uart_apb_master.sv
// -----------------------------------------------------------------------------
// uart_apb_master
//
// Bridges a UART byte stream to an APB requester. Command frames arrive on the
// RX side as:
//   'W' (0x57) A3 A2 A1 A0 D3 D2 D1 D0   -> APB write
//   'R' (0x52) A3 A2 A1 A0               -> APB read
// where address and data are MSB-first. Any other command byte is dropped.
// Each APB transfer answers on the TX side with 'K' (0x4B) for a good write,
// 'E' (0x45) for PSLVERR, or the four PRDATA bytes MSB-first for a good read.
//
// Optional feature (macro UART_APB_MASTER_TIMEOUT_EN):
//   Aborts an APB transfer after TIMEOUT_CYCLES ACCESS cycles without PREADY
//   and answers 'E'. Without the macro the bridge waits for PREADY forever.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rx_data_in/valid/ready   command byte stream from the UART RX FIFO
//   tx_data_out/valid/ready  response byte stream to the UART TX FIFO
//   PSEL..PWDATA             APB requester outputs
//   PRDATA, PREADY, PSLVERR  APB completer responses
//   busy                     high whenever a frame or transfer is in progress
// -----------------------------------------------------------------------------
module uart_apb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_in,
  input  logic        rx_valid_in,
  output logic        rx_ready_out,
  output logic [7:0]  tx_data_out,
  output logic        tx_valid_out,
  input  logic        tx_ready_in,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output logic        busy
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_apb_master: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  state_e      state_q;
  logic [1:0]  cnt_q;        // byte index within address, data or response
  logic        is_write_q;
  logic [31:0] addr_sh_q;    // address assembled byte by byte
  logic [23:0] wdata_sh_q;   // first three write-data bytes
  logic [23:0] rsp_sh_q;     // read-data bytes still to be sent
  logic        rsp_single_q; // response is a single status byte
  logic [31:0] paddr_q;
  logic [31:0] pwdata_q;
  logic        pwrite_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;

  logic        rx_fire;
  logic [31:0] addr_next;
  logic [31:0] wdata_next;

`ifdef UART_APB_MASTER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  // The counter holds the number of earlier wait cycles, so the cycle that
  // brings the total to TIMEOUT_CYCLES sees TIMEOUT_CYCLES-1 here.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q;
`endif

  // NOTE: rx_ready_out is gated by rst as well as the state so that no byte
  // is ever offered as accepted while reset is held, even before the first
  // reset edge has put the state register into IDLE.
  assign rx_ready_out = !rst && (state_q inside {S_IDLE, S_ADDR, S_WDATA});
  assign busy         = (state_q != S_IDLE);
  assign PSEL         = (state_q inside {S_SETUP, S_ACCESS});
  assign PENABLE      = (state_q == S_ACCESS);
  assign PADDR        = paddr_q;
  assign PWDATA       = pwdata_q;
  assign PWRITE       = pwrite_q;
  assign tx_data_out  = tx_data_q;
  assign tx_valid_out = tx_valid_q;

  assign rx_fire    = rx_valid_in && rx_ready_out;
  assign addr_next  = {addr_sh_q[23:0], rx_data_in};
  assign wdata_next = {wdata_sh_q, rx_data_in};

  // NOTE: every register below is assigned with <= so all state updates on an
  // edge see the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      is_write_q   <= 1'b0;
      addr_sh_q    <= '0;
      wdata_sh_q   <= '0;
      rsp_sh_q     <= '0;
      rsp_single_q <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pwrite_q     <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
`ifdef UART_APB_MASTER_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_fire) begin
            cnt_q <= '0;
            if (rx_data_in == CMD_WRITE) begin
              is_write_q <= 1'b1;
              state_q    <= S_ADDR;
            end else if (rx_data_in == CMD_READ) begin
              is_write_q <= 1'b0;
              state_q    <= S_ADDR;
            end
          end
        end

        S_ADDR: begin
          if (rx_fire) begin
            addr_sh_q <= addr_next;
            cnt_q     <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              if (is_write_q) begin
                state_q <= S_WDATA;
              end else begin
                // APB address phase fields change only when a new transfer
                // starts, so the bus keeps its last values between transfers.
                state_q  <= S_SETUP;
                paddr_q  <= addr_next;
                pwrite_q <= 1'b0;
              end
            end
          end
        end

        S_WDATA: begin
          if (rx_fire) begin
            wdata_sh_q <= wdata_next[23:0];
            cnt_q      <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_q  <= S_SETUP;
              paddr_q  <= addr_sh_q;
              pwdata_q <= wdata_next;
              pwrite_q <= 1'b1;
            end
          end
        end

        S_SETUP: begin
          state_q <= S_ACCESS;
`ifdef UART_APB_MASTER_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end

        S_ACCESS: begin
          if (PREADY) begin
            state_q    <= S_RESP;
            tx_valid_q <= 1'b1;
            cnt_q      <= '0;
            if (PSLVERR) begin
              tx_data_q    <= RSP_ERR;
              rsp_single_q <= 1'b1;
            end else if (is_write_q) begin
              tx_data_q    <= RSP_OK;
              rsp_single_q <= 1'b1;
            end else begin
              tx_data_q    <= PRDATA[31:24];
              rsp_sh_q     <= PRDATA[23:0];
              rsp_single_q <= 1'b0;
            end
          end
`ifdef UART_APB_MASTER_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_q      <= S_RESP;
            tx_valid_q   <= 1'b1;
            cnt_q        <= '0;
            tx_data_q    <= RSP_ERR;
            rsp_single_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end

        S_RESP: begin
          if (tx_ready_in) begin
            if (rsp_single_q || (cnt_q == 2'd3)) begin
              state_q    <= S_IDLE;
              tx_valid_q <= 1'b0;
            end else begin
              cnt_q     <= cnt_q + 2'd1;
              tx_data_q <= rsp_sh_q[23:16];
              rsp_sh_q  <= {rsp_sh_q[15:0], 8'h00};
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_master.sv
// -----------------------------------------------------------------------------
// tb_uart_apb_master
//
// Drives command frames into uart_apb_master, plays an APB completer with a
// configurable number of wait cycles, and collects TX bytes with a randomly
// stalling TX FIFO. Expected transfers and response bytes are derived from the
// frame contents; observed ones are collected by a monitor and compared.
// Define UART_APB_MASTER_TIMEOUT_EN to exercise the timeout build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_apb_master;

`ifdef UART_APB_MASTER_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data_in;
  logic        rx_valid_in;
  logic        rx_ready_out;
  logic [7:0]  tx_data_out;
  logic        tx_valid_out;
  logic        tx_ready_in;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic        busy;

  always #5 clk = ~clk;

  uart_apb_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data_in   (rx_data_in),
    .rx_valid_in  (rx_valid_in),
    .rx_ready_out (rx_ready_out),
    .tx_data_out  (tx_data_out),
    .tx_valid_out (tx_valid_out),
    .tx_ready_in  (tx_ready_in),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PWRITE       (PWRITE),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .PSLVERR      (PSLVERR),
    .busy         (busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    int          psel_cycles;
  } xfer_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // completer behaviour for the current transfer
  int          slv_waits = 0;
  logic        slv_err   = 1'b0;
  logic [31:0] slv_rdata = '0;

  // monitor results
  xfer_t       got_xfers[$];
  logic [7:0]  got_tx[$];
  logic [7:0]  exp_tx[$];
  int          rx_accepted = 0;
  int          last_rx_cyc = 0;
  int          first_tx_cyc = -1;
  int          acc_cycles = 0;
  int          psel_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor and APB completer. Runs 1 ns after each falling edge, when
  // stimulus set on the falling edge has settled and DUT outputs are stable.
  initial begin : monitor
    int          acc_k = 0;
    int          psel_cnt = 0;
    logic [31:0] s_addr = '0;
    logic [31:0] s_wdata = '0;
    logic        s_write = 1'b0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_tx = '0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0; tx_ready_in = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (PSEL) psel_total++;
      if (PSEL && !PENABLE) begin
        s_addr = PADDR; s_wdata = PWDATA; s_write = PWRITE;
        psel_cnt = 1; acc_k = 0; acc_cycles = 0;
      end else if (PSEL && PENABLE) begin
        psel_cnt++;
        acc_cycles++;
        check("paddr_stable", PADDR, s_addr);
        check("pwdata_stable", PWDATA, s_wdata);
        check("pwrite_stable", PWRITE, s_write);
      end
      if (PSEL && PENABLE && acc_k >= slv_waits) begin
        PREADY = 1'b1; PRDATA = slv_rdata; PSLVERR = slv_err;
        got_xfers.push_back('{addr: PADDR, write: PWRITE, wdata: PWDATA, psel_cycles: psel_cnt});
      end else begin
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
      end
      if (PSEL && PENABLE) acc_k++;

      if (prev_hold) begin
        check("tx_hold_valid", tx_valid_out, 1);
        check("tx_hold_data", tx_data_out, prev_tx);
      end
      tx_ready_in = ($urandom_range(0, 9) < 7);
      if (tx_valid_out && first_tx_cyc < 0) first_tx_cyc = cyc;
      if (tx_valid_out && tx_ready_in) got_tx.push_back(tx_data_out);
      prev_hold = tx_valid_out && !tx_ready_in;
      prev_tx   = tx_data_out;

      if (rx_valid_in && rx_ready_out) begin
        rx_accepted++;
        last_rx_cyc = cyc;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    if ($urandom_range(0, 3) == 0) begin
      @(negedge clk);
      rx_valid_in = 1'b0;
      rx_data_in  = 8'($urandom);
    end
    @(negedge clk);
    rx_data_in  = b;
    rx_valid_in = 1'b1;
    while (!rx_ready_out && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("rx_ready_when_sending", rx_ready_out, 1);
  endtask

  task automatic send_frame(input logic is_write, input logic [31:0] addr, input logic [31:0] wdata);
    send_byte(is_write ? 8'h57 : 8'h52);
    for (int i = 0; i < 4; i++) send_byte(8'(addr >> (24 - 8 * i)));
    if (is_write)
      for (int i = 0; i < 4; i++) send_byte(8'(wdata >> (24 - 8 * i)));
  endtask

  // One complete command/transfer/response round trip with checks.
  task automatic run_txn(input logic is_write, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic err, input logic [31:0] rdata,
                         input logic abort);
    int rx_base;
    int g;
    slv_waits = waits; slv_err = err; slv_rdata = rdata;
    first_tx_cyc = -1;
    rx_base = rx_accepted;
    if (abort || err)     exp_tx.push_back(8'h45);
    else if (is_write)    exp_tx.push_back(8'h4B);
    else for (int i = 0; i < 4; i++) exp_tx.push_back(8'(rdata >> (24 - 8 * i)));

    send_frame(is_write, addr, wdata);
    // A further byte waits in the RX FIFO; it must not be taken mid-transfer.
    @(negedge clk);
    rx_data_in = 8'hA5;
    g = 0;
    while (!tx_valid_out && g < (abort ? TMO : waits) + 20) begin
      @(negedge clk);
      g++;
    end
    check("tx_valid_seen", tx_valid_out, 1);
    rx_valid_in = 1'b0;
    g = 0;
    while (busy && g < 200) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);

    check("xfer_count", 32'(got_xfers.size()), abort ? 0 : 1);
    if (got_xfers.size() > 0 && !abort) begin
      check("xfer_addr", got_xfers[0].addr, addr);
      check("xfer_write", got_xfers[0].write, is_write);
      if (is_write) check("xfer_wdata", got_xfers[0].wdata, wdata);
      check("psel_cycles", got_xfers[0].psel_cycles, 2 + waits);
    end
    check("tx_count", 32'(got_tx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++)
      check("tx_byte", got_tx[i], exp_tx[i]);
    check("resp_latency", first_tx_cyc - last_rx_cyc, abort ? TMO + 2 : 3 + waits);
    check("access_cycles", acc_cycles, abort ? TMO : 1 + waits);
    check("rx_consumed", rx_accepted - rx_base, is_write ? 9 : 5);
    check("busy_after", busy, 0);
    got_xfers.delete();
    got_tx.delete();
    exp_tx.delete();
  endtask

  initial begin : stimulus
    int base_rx;
    int base_psel;
    int g;
    rst = 1'b1;
    rx_valid_in = 1'b0;
    rx_data_in  = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_rx_ready", rx_ready_out, 0);
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_tx_valid", tx_valid_out, 0);
    check("rst_tx_data", tx_data_out, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // directed frames
    run_txn(1'b1, 32'h4, 32'h41, 0, 1'b0, 32'h0, 1'b0);
    run_txn(1'b0, 32'h4, 32'h0, 0, 1'b0, 32'h3, 1'b0);
    run_txn(1'b1, 32'h1234_5678, 32'hCAFE_F00D, 3, 1'b0, 32'h0, 1'b0);
    run_txn(1'b0, 32'h10, 32'h0, 1, 1'b1, 32'hDEAD_BEEF, 1'b0);

    // unknown command is dropped without APB activity
    base_rx = rx_accepted;
    base_psel = psel_total;
    send_byte(8'h33);
    @(negedge clk);
    rx_valid_in = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    check("bad_cmd_consumed", rx_accepted - base_rx, 1);
    check("bad_cmd_no_apb", psel_total - base_psel, 0);
    check("bad_cmd_busy", busy, 0);
    check("bad_cmd_no_tx", 32'(got_tx.size()), 0);
    run_txn(1'b0, 32'h0, 32'h0, 0, 1'b0, 32'h8765_4321, 1'b0);

`ifdef UART_APB_MASTER_TIMEOUT_EN
    run_txn(1'b1, 32'hA0, 32'h55, 1000, 1'b0, 32'h0, 1'b1);
`else
    run_txn(1'b0, 32'hA0, 32'h0, 30, 1'b0, 32'h0102_0304, 1'b0);
`endif

    // reset in the middle of a frame discards it
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    rst = 1'b1;
    rx_valid_in = 1'b0;
    @(negedge clk);
    check("midframe_rst_busy", busy, 0);
    rst = 1'b0;
    run_txn(1'b0, 32'hC, 32'h0, 2, 1'b0, 32'h00FF_00FF, 1'b0);

    // reset during ACCESS: bus released at once, no response
    slv_waits = 1000;
    send_frame(1'b1, 32'h55AA_55AA, 32'h1111_2222);
    @(negedge clk);
    rx_valid_in = 1'b0;
    g = 0;
    while (!PENABLE && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("access_reached", PENABLE, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("access_rst_psel", PSEL, 0);
    check("access_rst_penable", PENABLE, 0);
    check("access_rst_rx_ready", rx_ready_out, 0);
    check("access_rst_busy", busy, 0);
    check("access_rst_paddr", PADDR, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    check("access_rst_no_tx", 32'(got_tx.size()), 0);
    check("access_rst_no_xfer", 32'(got_xfers.size()), 0);
    got_xfers.delete();

    // randomized frames
    for (int n = 0; n < 24; n++) begin
      run_txn(1'($urandom), $urandom, $urandom, $urandom_range(0, 4),
              ($urandom_range(0, 4) == 0), $urandom, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
